mkio_bc_scheduler: RTL and testbench

Bus-controller transaction scheduler for the MKIO (GOST 26765.52 / MIL-STD-1553) channel. It walks a small command table and issues one RT→BC transmit command word per entry to the channel transmitter. For each command it waits for the remote terminal's status word and data words, with a response timeout, and writes the received data words into an external buffer RAM. Bad transactions are retried once, and per-entry error and status-flag maps are reported at end of frame.

---
 rtl/mkio_pkg.sv | 30 +++
 rtl/mkio_resp_timer.sv | 38 +++
 rtl/mkio_bc_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_mkio_bc_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mkio_pkg.sv
// Shared definitions for the MKIO bus-controller scheduler: command word layout,
// FSM state encoding and the expected-word-count rule.
package mkio_pkg;

    localparam int CMD_RT_MSB = 15;
    localparam int CMD_RT_LSB = 11;
    localparam int CMD_TR_BIT = 10;
    localparam int CMD_N_MSB  = 4;
    localparam int CMD_N_LSB  = 0;
    localparam int SW_FLAG_MSB = 10;

    // A word count field of zero means a full 32-word transfer.
    localparam logic [5:0] WCNT_N0 = 6'd32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND_CMD,
        ST_WAIT_SW,
        ST_WAIT_DW,
        ST_FAIL,
        ST_NEXT,
        ST_DONE
    } state_t;

    function automatic logic [5:0] word_count(input logic [4:0] n);
        return (n == 5'd0) ? WCNT_N0 : {1'b0, n};
    endfunction

endpackage

// File: rtl/mkio_resp_timer.sv
// Response timeout: loadable down-counter that pulses o_expire once when it
// reaches zero, RESP_TIMEOUT cycles after the load cycle.
module mkio_resp_timer #(
    parameter int RESP_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_clr,
    output logic o_expire
);

    localparam int TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

    logic [TW-1:0] r_count;
    logic          r_armed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_armed <= 1'b0;
        end else if (i_clr) begin
            r_armed <= 1'b0;
        end else if (i_load) begin
            r_count <= TW'(RESP_TIMEOUT - 1);
            r_armed <= 1'b1;
        end else if (r_armed) begin
            if (r_count == '0) begin
                r_armed <= 1'b0;
            end else begin
                r_count <= r_count - TW'(1);
            end
        end
    end

    assign o_expire = r_armed && (r_count == '0);

endmodule

// File: rtl/mkio_bc_scheduler.sv
// MKIO bus-controller scheduler: walks the command table, issues RT->BC transmit
// commands, collects status/data words into the buffer RAM and retries failures.
module mkio_bc_scheduler
    import mkio_pkg::*;
#(
    parameter int NUM_CMDS     = 8,
    parameter int RESP_TIMEOUT = 64,
    parameter int MAX_RETRY    = 1,
    localparam int AW          = $clog2(NUM_CMDS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [15:0]         cfg_data,
    input  logic [AW:0]         cfg_count,
    output logic [15:0]         tx_data,
    output logic                tx_valid,
    output logic                tx_cd,
    input  logic [15:0]         rx_data,
    input  logic                rx_valid,
    input  logic                rx_cd,
    input  logic                rx_perr,
    output logic                buf_we,
    output logic [AW+4:0]       buf_addr,
    output logic [15:0]         buf_data,
    output logic                busy,
    output logic                done,
    output logic [NUM_CMDS-1:0] err_map,
    output logic [NUM_CMDS-1:0] sw_flag
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [15:0]         r_table [NUM_CMDS];
    state_t              r_state;
    logic [AW:0]         r_count;
    logic [AW-1:0]       r_idx;
    logic [RW-1:0]       r_retry;
    logic [4:0]          r_cmd_rt;
    logic [5:0]          r_wexp;
    logic [5:0]          r_wcnt;
    logic [15:0]         r_tx_data;
    logic                r_tx_valid;
    logic                r_tx_cd;
    logic                r_buf_we;
    logic [AW+4:0]       r_buf_addr;
    logic [15:0]         r_buf_data;
    logic                r_busy;
    logic                r_done;
    logic [NUM_CMDS-1:0] r_err_map;
    logic [NUM_CMDS-1:0] r_sw_flag;

    logic [15:0] w_entry;
    logic        w_sw_ok;
    logic        w_dw_ok;
    logic        w_last;
    logic        w_tmr_load;
    logic        w_tmr_clr;
    logic        w_tmr_expire;

    // NOTE: the command table is plain storage with no reset; only the control
    // state is reset, which keeps the array free of a reset fan-out.
    always_ff @(posedge clk) begin
        if (cfg_we && !r_busy) begin
            r_table[cfg_addr] <= cfg_data;
        end
    end

    assign w_entry = r_table[r_idx];
    assign w_sw_ok = rx_cd && !rx_perr && (rx_data[CMD_RT_MSB:CMD_RT_LSB] == r_cmd_rt);
    assign w_dw_ok = !rx_cd && !rx_perr;
    assign w_last  = ({1'b0, r_idx} == (r_count - (AW+1)'(1)));

    // The timer restarts on the command and on every accepted word.
    assign w_tmr_load = (r_state == ST_SEND_CMD)
                     || ((r_state == ST_WAIT_SW) && rx_valid && w_sw_ok && !w_tmr_expire)
                     || ((r_state == ST_WAIT_DW) && rx_valid && w_dw_ok && !w_tmr_expire);
    assign w_tmr_clr  = !((r_state == ST_SEND_CMD) || (r_state == ST_WAIT_SW)
                       || (r_state == ST_WAIT_DW));

    mkio_resp_timer #(
        .RESP_TIMEOUT (RESP_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_tmr_load),
        .i_clr    (w_tmr_clr),
        .o_expire (w_tmr_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_idx      <= '0;
            r_retry    <= '0;
            r_cmd_rt   <= '0;
            r_wexp     <= '0;
            r_wcnt     <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_cd    <= 1'b0;
            r_buf_we   <= 1'b0;
            r_buf_addr <= '0;
            r_buf_data <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err_map  <= '0;
            r_sw_flag  <= '0;
        end else begin
            // NOTE: strobes default low each cycle so every branch yields a single-cycle pulse.
            r_tx_valid <= 1'b0;
            r_buf_we   <= 1'b0;
            r_done     <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        if (cfg_count == '0) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_err_map <= '0;
                            r_sw_flag <= '0;
                            r_count   <= cfg_count;
                            r_idx     <= '0;
                            r_retry   <= '0;
                            r_busy    <= 1'b1;
                            r_state   <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    r_cmd_rt <= w_entry[CMD_RT_MSB:CMD_RT_LSB];
                    r_wexp   <= word_count(w_entry[CMD_N_MSB:CMD_N_LSB]);
                    if (!w_entry[CMD_TR_BIT]) begin
                        r_err_map[r_idx] <= 1'b1;
                        r_state          <= ST_NEXT;
                    end else begin
                        r_tx_data  <= w_entry;
                        r_tx_cd    <= 1'b1;
                        r_tx_valid <= 1'b1;
                        r_state    <= ST_SEND_CMD;
                    end
                end
                ST_SEND_CMD: begin
                    r_wcnt  <= '0;
                    r_state <= ST_WAIT_SW;
                end
                ST_WAIT_SW: begin
                    if (w_tmr_expire) begin
                        r_state <= ST_FAIL;
                    end else if (rx_valid) begin
                        if (w_sw_ok) begin
                            r_sw_flag[r_idx] <= r_sw_flag[r_idx] | (|rx_data[SW_FLAG_MSB:0]);
                            r_state          <= ST_WAIT_DW;
                        end else begin
                            r_state <= ST_FAIL;
                        end
                    end
                end
                ST_WAIT_DW: begin
                    if (w_tmr_expire) begin
                        r_state <= ST_FAIL;
                    end else if (rx_valid) begin
                        if (w_dw_ok) begin
                            r_buf_we   <= 1'b1;
                            r_buf_addr <= {r_idx, r_wcnt[4:0]};
                            r_buf_data <= rx_data;
                            r_wcnt     <= r_wcnt + 6'd1;
                            if ((r_wcnt + 6'd1) == r_wexp) begin
                                r_state <= ST_NEXT;
                            end
                        end else begin
                            r_state <= ST_FAIL;
                        end
                    end
                end
                ST_FAIL: begin
                    if (r_retry < RW'(MAX_RETRY)) begin
                        r_retry <= r_retry + RW'(1);
                        r_state <= ST_LOAD;
                    end else begin
                        r_err_map[r_idx] <= 1'b1;
                        r_state          <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    r_retry <= '0;
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx + AW'(1);
                        r_state <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign tx_cd    = r_tx_cd;
    assign buf_we   = r_buf_we;
    assign buf_addr = r_buf_addr;
    assign buf_data = r_buf_data;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err_map  = r_err_map;
    assign sw_flag  = r_sw_flag;

endmodule

// File: tb/tb_mkio_bc_scheduler.sv
// Bench for mkio_bc_scheduler: acts as the remote terminal, predicts buffer writes
// and end-of-frame maps from the transaction rules, and checks the DUT against them.
module tb_mkio_bc_scheduler;

    localparam int NUM_CMDS     = 8;
    localparam int AW           = 3;
    localparam int RESP_TIMEOUT = 64;
    localparam int MAX_RETRY    = 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                run;
    logic                cfg_we;
    logic [AW-1:0]       cfg_addr;
    logic [15:0]         cfg_data;
    logic [AW:0]         cfg_count;
    logic [15:0]         tx_data;
    logic                tx_valid;
    logic                tx_cd;
    logic [15:0]         rx_data;
    logic                rx_valid;
    logic                rx_cd;
    logic                rx_perr;
    logic                buf_we;
    logic [AW+4:0]       buf_addr;
    logic [15:0]         buf_data;
    logic                busy;
    logic                done;
    logic [NUM_CMDS-1:0] err_map;
    logic [NUM_CMDS-1:0] sw_flag;

    always #5 clk = ~clk;

    mkio_bc_scheduler #(
        .NUM_CMDS     (NUM_CMDS),
        .RESP_TIMEOUT (RESP_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_count (cfg_count),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_cd     (tx_cd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_cd     (rx_cd),
        .rx_perr   (rx_perr),
        .buf_we    (buf_we),
        .buf_addr  (buf_addr),
        .buf_data  (buf_data),
        .busy      (busy),
        .done      (done),
        .err_map   (err_map),
        .sw_flag   (sw_flag)
    );

    int n_vec = 0;
    int n_bad = 0;
    int n_tx_mon = 0;

    logic [15:0]         tbl [NUM_CMDS];
    logic [NUM_CMDS-1:0] exp_err;
    logic [NUM_CMDS-1:0] exp_sw;
    logic [AW+20:0]      exp_q [$];
    logic [AW+20:0]      got_q [$];

    always @(negedge clk) begin
        if (buf_we) got_q.push_back({buf_addr, buf_data});
        if (tx_valid) n_tx_mon++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic write_tbl(input int i, input logic [15:0] w);
        tbl[i]   = w;
        cfg_we   = 1'b1;
        cfg_addr = AW'(i);
        cfg_data = w;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic start_frame(input int cnt);
        got_q.delete();
        exp_q.delete();
        exp_err  = '0;
        exp_sw   = '0;
        n_tx_mon = 0;
        cfg_count = (AW+1)'(cnt);
        run = 1'b1;
        tick();
        run = 1'b0;
        check("busy_after_run", busy, 1'b1);
    endtask

    task automatic rx_word(input logic [15:0] d, input logic cd, input logic perr);
        rx_data  = d;
        rx_cd    = cd;
        rx_perr  = perr;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_cd    = 1'b0;
        rx_perr  = 1'b0;
        rx_data  = '0;
    endtask

    task automatic rx_dword(input int i, input int j, input logic [15:0] d);
        logic [AW-1:0] ia;
        logic [4:0]    ja;
        ia = AW'(i);
        ja = 5'(j);
        exp_q.push_back({ia, ja, d});
        rx_word(d, 1'b0, 1'b0);
    endtask

    task automatic wait_tx(input logic [15:0] c, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!tx_valid && n < 200);
        check("tx_seen", tx_valid, 1'b1);
        check("tx_data", tx_data, c);
        check("tx_cd", tx_cd, 1'b1);
    endtask

    task automatic finish_frame();
        int n;
        n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        check("done_seen", done, 1'b1);
        check("busy_at_done", busy, 1'b0);
        check("err_map", err_map, exp_err);
        check("sw_flag", sw_flag, exp_sw);
        check("n_writes", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            check($sformatf("buf_write[%0d]", k), got_q[k], exp_q[k]);
        end
        tick();
        check("done_one_cycle", done, 1'b0);
    endtask

    // Drives the remote terminal for one table entry with randomly chosen outcomes.
    task automatic run_entry(input int i);
        logic [15:0] c;
        logic [15:0] sw;
        int          wexp;
        int          mode;
        int          k;
        int          n;
        c    = tbl[i];
        wexp = (c[4:0] == 5'd0) ? 32 : int'(c[4:0]);
        if (!c[10]) begin
            exp_err[i] = 1'b1;
            return;
        end
        for (int a = 0; a <= MAX_RETRY; a++) begin
            mode = $urandom_range(0, 11);
            if (mode > 7) mode = 0;
            wait_tx(c, n);
            idle($urandom_range(1, 8));
            sw = {c[15:11], 11'd0};
            if ($urandom_range(0, 2) == 0) sw[$urandom_range(0, 10)] = 1'b1;
            case (mode)
                1: ;
                2: rx_word({c[15:11] ^ 5'($urandom_range(1, 31)), sw[10:0]}, 1'b1, 1'b0);
                3: rx_word(sw, 1'b1, 1'b1);
                4: rx_word(sw, 1'b0, 1'b0);
                default: begin
                    rx_word(sw, 1'b1, 1'b0);
                    exp_sw[i] = exp_sw[i] | (|sw[10:0]);
                    k = (mode == 0) ? wexp : $urandom_range(0, wexp - 1);
                    for (int j = 0; j < k; j++) begin
                        idle($urandom_range(0, 2));
                        rx_dword(i, j, 16'($urandom));
                    end
                    if (mode == 0) return;
                    idle($urandom_range(0, 2));
                    if (mode == 5) rx_word(16'($urandom), 1'b0, 1'b1);
                    if (mode == 7) rx_word(16'($urandom), 1'b1, 1'b0);
                end
            endcase
        end
        exp_err[i] = 1'b1;
    endtask

    initial begin
        int n;
        int cnt;
        logic [15:0] w;

        reset = 1'b1;
        run = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_count = '0;
        rx_data = '0; rx_valid = 1'b0; rx_cd = 1'b0; rx_perr = 1'b0;
        idle(2);
        check("reset_values", {tx_data, tx_valid, tx_cd, buf_we, buf_addr, buf_data, busy, done, err_map, sw_flag}, 64'd0);
        reset = 1'b0;
        tick();

        // Single good entry: RT1 SA1 N=3, exact command latency.
        write_tbl(0, 16'h0C23);
        start_frame(1);
        wait_tx(16'h0C23, n);
        check("tx_latency", n, 1);
        tick();
        check("tx_one_cycle", tx_valid, 1'b0);
        rx_word(16'h0800, 1'b1, 1'b0);
        rx_dword(0, 0, 16'h1111);
        rx_dword(0, 1, 16'h2222);
        rx_dword(0, 2, 16'h3333);
        finish_frame();

        // N=0 entry: 32 words back to back, done right after the last write.
        write_tbl(0, {5'd3, 1'b1, 5'd2, 5'd0});
        start_frame(1);
        wait_tx(tbl[0], n);
        idle(1);
        rx_word({5'd3, 11'd0}, 1'b1, 1'b0);
        for (int j = 0; j < 32; j++) rx_dword(0, j, 16'($urandom));
        check("last_write_strobe", buf_we, 1'b1);
        check("done_not_yet", done, 1'b0);
        tick();
        check("done_after_last_write", done, 1'b1);
        finish_frame();

        // Silent RT: two commands separated by the timeout, then error.
        write_tbl(0, 16'h0C23);
        start_frame(1);
        wait_tx(16'h0C23, n);
        wait_tx(16'h0C23, n);
        check("retry_gap", n, RESP_TIMEOUT + 3);
        exp_err = 8'h01;
        finish_frame();
        check("silent_tx_count", n_tx_mon, 2);

        // Responses arriving one cycle before the timeout are accepted.
        write_tbl(0, {5'd9, 1'b1, 5'd4, 5'd2});
        start_frame(1);
        wait_tx(tbl[0], n);
        idle(RESP_TIMEOUT - 1);
        rx_word({5'd9, 11'd0}, 1'b1, 1'b0);
        idle(RESP_TIMEOUT - 2);
        rx_dword(0, 0, 16'hA5A5);
        rx_dword(0, 1, 16'h5A5A);
        finish_frame();

        // Two entries: address mismatch twice, then good with SW bit 10.
        write_tbl(0, {5'd5, 1'b1, 5'd1, 5'd1});
        write_tbl(1, {5'd6, 1'b1, 5'd2, 5'd2});
        start_frame(2);
        wait_tx(tbl[0], n);
        idle(2);
        rx_word({5'd7, 11'd0}, 1'b1, 1'b0);
        wait_tx(tbl[0], n);
        idle(2);
        rx_word({5'd4, 11'h7FF}, 1'b1, 1'b0);
        wait_tx(tbl[1], n);
        idle(1);
        rx_word({5'd6, 11'h400}, 1'b1, 1'b0);
        rx_dword(1, 0, 16'hBEEF);
        rx_dword(1, 1, 16'hCAFE);
        exp_err = 8'h01;
        exp_sw  = 8'h02;
        finish_frame();

        // BC->RT entry is rejected without bus activity.
        write_tbl(0, {5'd2, 1'b0, 5'd3, 5'd4});
        start_frame(1);
        exp_err = 8'h01;
        finish_frame();
        check("no_tx_for_bc_rt", n_tx_mon, 0);

        // Zero active entries: done without going busy.
        cfg_count = '0;
        n_tx_mon = 0;
        run = 1'b1;
        tick();
        run = 1'b0;
        check("count0_done", {busy, done}, 2'b01);
        check("count0_no_tx", n_tx_mon, 0);
        tick();

        // run and cfg_we while busy are ignored.
        write_tbl(0, 16'h0C23);
        start_frame(1);
        wait_tx(16'h0C23, n);
        run = 1'b1; cfg_we = 1'b1; cfg_addr = '0; cfg_data = 16'hFFFF;
        tick();
        run = 1'b0; cfg_we = 1'b0;
        rx_word(16'h0801, 1'b1, 1'b0);
        rx_dword(0, 0, 16'h0001);
        rx_dword(0, 1, 16'h0002);
        rx_dword(0, 2, 16'h0003);
        exp_sw = 8'h01;
        finish_frame();
        check("busy_run_ignored", n_tx_mon, 1);
        start_frame(1);
        wait_tx(16'h0C23, n);
        idle(3);
        rx_word(16'h0800, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) rx_dword(0, j, 16'($urandom));
        finish_frame();

        // Reset during WAIT_DW aborts at once; a new frame then runs normally.
        start_frame(1);
        wait_tx(16'h0C23, n);
        idle(1);
        rx_word(16'h0800, 1'b1, 1'b0);
        rx_word(16'h1234, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("reset_abort", {tx_data, tx_valid, tx_cd, buf_we, buf_addr, buf_data, busy, done, err_map, sw_flag}, 64'd0);
        rx_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("reset_quiet", {tx_valid, buf_we}, 2'b00);
        end
        rx_valid = 1'b0;
        reset = 1'b0;
        tick();
        write_tbl(0, 16'h0C23);
        start_frame(1);
        wait_tx(16'h0C23, n);
        idle(2);
        rx_word(16'h0800, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) rx_dword(0, j, 16'($urandom));
        finish_frame();

        // Randomized frames.
        for (int f = 0; f < 8; f++) begin
            cnt = $urandom_range(1, NUM_CMDS);
            for (int i = 0; i < NUM_CMDS; i++) begin
                w = 16'($urandom);
                w[10] = ($urandom_range(0, 7) != 0);
                w[4:0] = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 4));
                write_tbl(i, w);
            end
            start_frame(cnt);
            for (int i = 0; i < cnt; i++) run_entry(i);
            finish_frame();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
